// File: rtl/wb_pkg.sv
// ============================================================================
// wb_pkg : shared types for the writeback unit (load-size codes, stage types)
// Revision: 1.0
// ============================================================================
`default_nettype none

package wb_pkg;

  localparam int MAX_XLEN = 64;
  localparam int MAX_AW   = 16;

  typedef enum logic [2:0] {
    SZ_LB   = 3'b000,
    SZ_LH   = 3'b001,
    SZ_LW   = 3'b010,
    SZ_LD   = 3'b011,
    SZ_LBU  = 3'b100,
    SZ_LHU  = 3'b101,
    SZ_LWU  = 3'b110,
    SZ_RSVD = 3'b111
  } ld_size_e;

  typedef enum logic [0:0] {
    STAGE_EMPTY = 1'b0,
    STAGE_FULL  = 1'b1
  } stage_state_e;

  // Sized for the widest legal configuration; narrower builds zero-pad.
  typedef struct packed {
    logic                we;
    logic [MAX_AW-1:0]   rd;
    logic [MAX_XLEN-1:0] value;
  } stage_entry_t;

endpackage

`default_nettype wire

// File: rtl/wb_load_ext.sv
// ============================================================================
// wb_load_ext : combinational result select and load sign/zero extension
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            sel,
  input  logic [2:0]      size,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] ld,
  output logic [XLEN-1:0] value
);

  always_comb begin
    value = ld;
    if (!sel) begin
      value = alu;
    end else begin
      case (ld_size_e'(size))
        SZ_LB:   value = XLEN'($signed(ld[7:0]));
        SZ_LH:   value = XLEN'($signed(ld[15:0]));
        SZ_LW:   value = XLEN'($signed(ld[31:0]));
        SZ_LBU:  value = XLEN'(ld[7:0]);
        SZ_LHU:  value = XLEN'(ld[15:0]);
        SZ_LWU:  value = XLEN'(ld[31:0]);
        // LD is a pass-through at either XLEN; the reserved code passes too.
        default: value = ld;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/writeback_unit.sv
// ============================================================================
// writeback_unit : one-entry WB stage, register file, forwarding, retire count
// Optional macro WB_BYPASS_EN: read ports bypass the committing staged value.
// Revision: 1.0
// ============================================================================
`default_nettype none

module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRP   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [AW-1:0]       in_rd,
  input  logic                in_we,
  input  logic                in_sel,
  input  logic [2:0]          in_size,
  input  logic [XLEN-1:0]     in_alu,
  input  logic [XLEN-1:0]     in_ld,
  input  logic                wb_stall,
  input  logic                wb_flush,
  input  logic [NRP*AW-1:0]   rs_addr,
  output logic [NRP*XLEN-1:0] rs_data,
  output logic                fwd_valid,
  output logic [AW-1:0]       fwd_rd,
  output logic [XLEN-1:0]     fwd_val,
  output logic [63:0]         retire_cnt
);

  stage_state_e    state, state_next;
  stage_entry_t    entry;
  logic [XLEN-1:0] ext_value;
  logic [XLEN-1:0] gpr [NREGS];
  logic            stage_valid;
  logic            commit;
  logic            xfer;
  logic            unused_stage;

  wb_load_ext #(.XLEN(XLEN)) u_ext (
    .sel   (in_sel),
    .size  (in_size),
    .alu   (in_alu),
    .ld    (in_ld),
    .value (ext_value)
  );

  assign stage_valid = (state == STAGE_FULL);
  assign in_ready    = !stage_valid || (!wb_stall && !wb_flush);
  assign commit      = stage_valid && !wb_stall && !wb_flush;
  assign xfer        = in_valid && in_ready;

  assign fwd_rd       = entry.rd[AW-1:0];
  assign fwd_val      = entry.value[XLEN-1:0];
  assign fwd_valid    = stage_valid && entry.we && (fwd_rd != '0);
  assign unused_stage = ^entry;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= STAGE_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Flush forces in_ready low, so a flushed stage can never refill that edge.
  always_comb begin
    state_next = state;
    case (state)
      STAGE_EMPTY: if (xfer) state_next = STAGE_FULL;
      STAGE_FULL: begin
        if (wb_flush)     state_next = STAGE_EMPTY;
        else if (commit)  state_next = xfer ? STAGE_FULL : STAGE_EMPTY;
      end
      default:            state_next = STAGE_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      entry      <= '0;
      retire_cnt <= '0;
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else begin
      if (xfer) begin
        entry.we    <= in_we;
        entry.rd    <= MAX_AW'(in_rd);
        entry.value <= MAX_XLEN'(ext_value);
      end
      if (commit) begin
        retire_cnt <= retire_cnt + 64'd1;
        if (fwd_valid) gpr[fwd_rd] <= fwd_val;
      end
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd_port
    logic [AW-1:0] addr;
    assign addr = rs_addr[k*AW +: AW];
`ifdef WB_BYPASS_EN
    assign rs_data[k*XLEN +: XLEN] =
      (fwd_valid && (fwd_rd == addr) && !wb_stall && !wb_flush) ? fwd_val : gpr[addr];
`else
    assign rs_data[k*XLEN +: XLEN] = gpr[addr];
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_writeback_unit.sv
// ============================================================================
// tb_writeback_unit : directed and random checks against a behavioural model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = '0;
  logic        in_we = 1'b0;
  logic        in_sel = 1'b0;
  logic [2:0]  in_size = '0;
  logic [63:0] in_alu = '0;
  logic [63:0] in_ld = '0;
  logic        wb_stall = 1'b0;
  logic        wb_flush = 1'b0;
  logic [9:0]  rs_addr = '0;
  logic [127:0] rs_data;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [63:0] fwd_val;
  logic [63:0] retire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the architectural state
  bit          m_full;
  bit          m_we;
  int          m_rd;
  logic [63:0] m_val;
  logic [63:0] m_gpr [32];
  logic [63:0] m_cnt;

  writeback_unit dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_we(in_we), .in_sel(in_sel), .in_size(in_size),
    .in_alu(in_alu), .in_ld(in_ld), .wb_stall(wb_stall), .wb_flush(wb_flush),
    .rs_addr(rs_addr), .rs_data(rs_data), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_val(fwd_val), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fit(logic [63:0] v, int n, bit sgn);
    logic [63:0] mask;
    logic [63:0] m;
    mask = (64'd1 << n) - 64'd1;
    m = v & mask;
    if (sgn && (((m >> (n - 1)) & 64'd1) != 0)) m = m | ~mask;
    return m;
  endfunction

  function automatic logic [63:0] m_ext(bit sel, int size, logic [63:0] alu, logic [63:0] ld);
    if (!sel) return alu;
    case (size)
      0: return fit(ld, 8, 1);
      1: return fit(ld, 16, 1);
      2: return fit(ld, 32, 1);
      4: return fit(ld, 8, 0);
      5: return fit(ld, 16, 0);
      6: return fit(ld, 32, 0);
      default: return ld;
    endcase
  endfunction

  function automatic logic [63:0] m_read(int addr);
`ifdef WB_BYPASS_EN
    if (m_full && m_we && m_rd != 0 && m_rd == addr && !wb_stall && !wb_flush) return m_val;
`endif
    return m_gpr[addr];
  endfunction

  task automatic model_reset();
    m_full = 0; m_we = 0; m_rd = 0; m_val = '0; m_cnt = '0;
    for (int i = 0; i < 32; i++) m_gpr[i] = '0;
  endtask

  // One clock edge; the model applies the same transaction rules at the edge.
  task automatic cycle();
    bit rdy, cmt, xf;
    rdy = !m_full || (!wb_stall && !wb_flush);
    cmt = m_full && !wb_stall && !wb_flush;
    xf  = in_valid && rdy;
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else begin
      if (cmt) begin
        if (m_we && m_rd != 0) m_gpr[m_rd] = m_val;
        m_cnt = m_cnt + 64'd1;
      end
      if (xf) begin
        m_full = 1; m_we = in_we; m_rd = int'(in_rd);
        m_val = m_ext(in_sel, int'(in_size), in_alu, in_ld);
      end else if (cmt || wb_flush) begin
        m_full = 0;
      end
    end
    #1;
  endtask

  task automatic drive(bit v, int rd, bit we, bit sel, int size, logic [63:0] alu, logic [63:0] ld);
    in_valid = v; in_rd = 5'(rd); in_we = we; in_sel = sel;
    in_size = 3'(size); in_alu = alu; in_ld = ld;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1, 9, 1, 0, 0, 64'hDEAD_BEEF, '0);
    cycle(); cycle();
    n_checks += 5;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
    if (fwd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_fwd_valid got %b want 0", fwd_valid); end
    if (fwd_rd !== 5'd0) begin n_errors++; $display("FAIL reset_fwd_rd got %0d want 0", fwd_rd); end
    if (fwd_val !== 64'd0) begin n_errors++; $display("FAIL reset_fwd_val got %h want 0", fwd_val); end
    if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", retire_cnt); end
    for (int r = 0; r < 32; r += 2) begin
      rs_addr = {5'(r + 1), 5'(r)}; #1;
      n_checks++;
      if (rs_data !== 128'd0) begin n_errors++; $display("FAIL reset_gpr r%0d got %h want 0", r, rs_data); end
    end
    drive(0, 0, 0, 0, 0, '0, '0);
    reset = 1'b1; #1;
  endtask

  task automatic test_lb();
    drive(1, 5, 1, 1, 0, 64'h0, 64'h80);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    n_checks += 3;
    if (fwd_valid !== 1'b1) begin n_errors++; $display("FAIL lb_fwd_valid got %b want 1", fwd_valid); end
    if (fwd_rd !== 5'd5) begin n_errors++; $display("FAIL lb_fwd_rd got %0d want 5", fwd_rd); end
    if (fwd_val !== 64'hFFFF_FFFF_FFFF_FF80) begin n_errors++; $display("FAIL lb_fwd_val got %h want ffffffffffffff80", fwd_val); end
    cycle();
    rs_addr = {5'd0, 5'd5}; #1;
    n_checks += 3;
    if (rs_data[63:0] !== 64'hFFFF_FFFF_FFFF_FF80) begin n_errors++; $display("FAIL lb_gpr5 got %h want ffffffffffffff80", rs_data[63:0]); end
    if (rs_data[127:64] !== 64'd0) begin n_errors++; $display("FAIL lb_gpr0 got %h want 0", rs_data[127:64]); end
    if (retire_cnt !== 64'd1) begin n_errors++; $display("FAIL lb_cnt got %0d want 1", retire_cnt); end
  endtask

  task automatic test_lhu_alu_r0();
    drive(1, 3, 1, 1, 5, '0, 64'hFFFF_8001);
    cycle();
    n_checks++;
    if (fwd_val !== 64'h8001) begin n_errors++; $display("FAIL lhu_val got %h want 8001", fwd_val); end
    drive(1, 0, 1, 0, 0, 64'h1234, '0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    n_checks++;
    if (fwd_valid !== 1'b0) begin n_errors++; $display("FAIL r0_fwd_valid got %b want 0", fwd_valid); end
    cycle();
    rs_addr = {5'd3, 5'd0}; #1;
    n_checks += 3;
    if (rs_data[63:0] !== 64'd0) begin n_errors++; $display("FAIL r0_gpr got %h want 0", rs_data[63:0]); end
    if (rs_data[127:64] !== 64'h8001) begin n_errors++; $display("FAIL lhu_gpr3 got %h want 8001", rs_data[127:64]); end
    if (retire_cnt !== m_cnt) begin n_errors++; $display("FAIL r0_cnt got %0d want %0d", retire_cnt, m_cnt); end
  endtask

  task automatic test_stall();
    logic [63:0] cnt0;
    drive(1, 9, 1, 0, 0, 64'h0909_0909_0909_0909, '0);
    cycle();
    cnt0 = m_cnt;
    wb_stall = 1'b1;
    drive(1, 10, 1, 0, 0, 64'hA0A0, '0);
    rs_addr = {5'd9, 5'd9};
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks += 3;
      if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_ready c%0d got %b want 0", i, in_ready); end
      if (rs_data[63:0] !== m_read(9)) begin n_errors++; $display("FAIL stall_gpr9 c%0d got %h want %h", i, rs_data[63:0], m_read(9)); end
      if (retire_cnt !== cnt0) begin n_errors++; $display("FAIL stall_cnt c%0d got %0d want %0d", i, retire_cnt, cnt0); end
      cycle();
    end
    wb_stall = 1'b0; #1;
    n_checks++;
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL stall_release_ready got %b want 1", in_ready); end
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    n_checks += 3;
    if (retire_cnt !== cnt0 + 64'd1) begin n_errors++; $display("FAIL stall_commit_cnt got %0d want %0d", retire_cnt, cnt0 + 64'd1); end
    if (fwd_rd !== 5'd10 || fwd_valid !== 1'b1) begin n_errors++; $display("FAIL stall_b2b got rd %0d v %b want rd 10 v 1", fwd_rd, fwd_valid); end
    if (rs_data[63:0] !== 64'h0909_0909_0909_0909) begin n_errors++; $display("FAIL stall_gpr9_commit got %h want 0909090909090909", rs_data[63:0]); end
    cycle();
  endtask

  task automatic test_flush();
    logic [63:0] cnt0, old12;
    old12 = m_gpr[12];
    drive(1, 12, 1, 0, 0, 64'hF1F1, '0);
    cycle();
    cnt0 = m_cnt;
    wb_flush = 1'b1; wb_stall = 1'b1;
    drive(1, 13, 1, 0, 0, 64'h1313, '0);
    #1;
    n_checks++;
    if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_ready got %b want 0", in_ready); end
    cycle();
    wb_flush = 1'b0; wb_stall = 1'b0;
    drive(0, 0, 0, 0, 0, '0, '0);
    rs_addr = {5'd13, 5'd12}; #1;
    n_checks += 4;
    if (fwd_valid !== 1'b0) begin n_errors++; $display("FAIL flush_fwd_valid got %b want 0", fwd_valid); end
    if (retire_cnt !== cnt0) begin n_errors++; $display("FAIL flush_cnt got %0d want %0d", retire_cnt, cnt0); end
    if (rs_data[63:0] !== old12) begin n_errors++; $display("FAIL flush_gpr12 got %h want %h", rs_data[63:0], old12); end
    if (rs_data[127:64] !== m_gpr[13]) begin n_errors++; $display("FAIL flush_gpr13 got %h want %h", rs_data[127:64], m_gpr[13]); end
  endtask

  task automatic test_bypass();
    logic [63:0] want;
    drive(1, 7, 1, 0, 0, 64'h55, '0);
    cycle();
    drive(1, 7, 1, 0, 0, 64'hAA, '0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    rs_addr = {5'd7, 5'd2}; #1;
`ifdef WB_BYPASS_EN
    want = 64'hAA;
`else
    want = 64'h55;
`endif
    n_checks += 2;
    if (rs_data[127:64] !== want) begin n_errors++; $display("FAIL bypass_rs1 got %h want %h", rs_data[127:64], want); end
    if (rs_data[63:0] !== m_gpr[2]) begin n_errors++; $display("FAIL bypass_rs0 got %h want %h", rs_data[63:0], m_gpr[2]); end
    cycle();
  endtask

  task automatic test_random();
    logic [4:0] a0, a1;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 5) != 0,
            $urandom_range(0, 1), $urandom_range(0, 7),
            {$urandom, $urandom}, {$urandom, $urandom});
      wb_stall = ($urandom_range(0, 4) == 0);
      wb_flush = ($urandom_range(0, 9) == 0);
      a0 = 5'($urandom_range(0, 31));
      a1 = (i % 3 == 0) ? 5'(m_rd) : 5'($urandom_range(0, 31));
      rs_addr = {a1, a0}; #1;
      n_checks += 5;
      if (in_ready !== (!m_full || (!wb_stall && !wb_flush))) begin n_errors++; $display("FAIL rand_ready i%0d got %b", i, in_ready); end
      if (fwd_valid !== (m_full && m_we && m_rd != 0)) begin n_errors++; $display("FAIL rand_fwd_valid i%0d got %b", i, fwd_valid); end
      if (rs_data[63:0] !== m_read(int'(a0))) begin n_errors++; $display("FAIL rand_rs0 i%0d got %h want %h", i, rs_data[63:0], m_read(int'(a0))); end
      if (rs_data[127:64] !== m_read(int'(a1))) begin n_errors++; $display("FAIL rand_rs1 i%0d got %h want %h", i, rs_data[127:64], m_read(int'(a1))); end
      if (retire_cnt !== m_cnt) begin n_errors++; $display("FAIL rand_cnt i%0d got %0d want %0d", i, retire_cnt, m_cnt); end
      if (m_full) begin
        n_checks++;
        if (fwd_rd !== 5'(m_rd) || fwd_val !== m_val) begin n_errors++; $display("FAIL rand_fwd i%0d got %0d/%h want %0d/%h", i, fwd_rd, fwd_val, m_rd, m_val); end
      end
      cycle();
    end
    drive(0, 0, 0, 0, 0, '0, '0);
    wb_stall = 1'b0; wb_flush = 1'b0;
    cycle(); cycle();
    for (int r = 0; r < 32; r++) begin
      rs_addr = {5'd0, 5'(r)}; #1;
      n_checks++;
      if (rs_data[63:0] !== m_gpr[r]) begin n_errors++; $display("FAIL rand_final r%0d got %h want %h", r, rs_data[63:0], m_gpr[r]); end
    end
  endtask

  task automatic test_wrap();
    force dut.retire_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.retire_cnt;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    drive(1, 20, 1, 0, 0, 64'h2020, '0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    n_checks++;
    if (retire_cnt !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_errors++; $display("FAIL wrap_preload got %h want all ones", retire_cnt); end
    cycle();
    n_checks++;
    if (retire_cnt !== 64'd0 || m_cnt !== 64'd0) begin n_errors++; $display("FAIL wrap_cnt got %h want 0", retire_cnt); end
  endtask

  task automatic test_reset_midop();
    drive(1, 4, 1, 0, 0, 64'h4444, '0);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    reset = 1'b0; #1;
    n_checks += 5;
    if (fwd_valid !== 1'b0) begin n_errors++; $display("FAIL rst_mid_fwd_valid got %b want 0", fwd_valid); end
    if (fwd_rd !== 5'd0 || fwd_val !== 64'd0) begin n_errors++; $display("FAIL rst_mid_fwd got %0d/%h want 0/0", fwd_rd, fwd_val); end
    if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rst_mid_ready got %b want 1", in_ready); end
    if (retire_cnt !== 64'd0) begin n_errors++; $display("FAIL rst_mid_cnt got %0d want 0", retire_cnt); end
    rs_addr = {5'd20, 5'd4}; #1;
    if (rs_data !== 128'd0) begin n_errors++; $display("FAIL rst_mid_gpr got %h want 0", rs_data); end
    cycle();
    reset = 1'b1; #1;
    drive(1, 6, 1, 1, 2, '0, 64'h8000_0000);
    cycle();
    drive(0, 0, 0, 0, 0, '0, '0);
    n_checks++;
    if (fwd_valid !== 1'b1 || fwd_rd !== 5'd6 || fwd_val !== 64'hFFFF_FFFF_8000_0000) begin
      n_errors++; $display("FAIL rst_first_xfer got %b/%0d/%h want 1/6/ffffffff80000000", fwd_valid, fwd_rd, fwd_val);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lb();
    test_lhu_alu_r0();
    test_stall();
    test_flush();
    test_bypass();
    test_random();
    test_wrap();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
